spi_slave_sampler: RTL and testbench
====================================

Name: spi_slave_sampler

Overview:
- Single-clock SPI slave endpoint. It consumes the mosi/sclk/cs stream produced by the SPI master and returns miso to it.
- sclk, cs_n and mosi are oversampled in the system clock domain, so the block needs no second clock.
- Supports all four cpol/cpha modes, MSB first, and back-to-back words while cs_n stays low.
- Presents received words to local logic through a valid/ack handshake, and accepts transmit words through a one-deep holding buffer.

Parameters:
- WIDTH, 8, bits per SPI word.
- SYNC_STAGES, 2, flip-flop depth of the sclk/cs_n/mosi synchronizers (minimum 2).
- TX_DEFAULT, 8'hFF, word shifted out when the tx buffer is empty at a word boundary.

Ports:
- clk, input, 1, system clock. All logic is on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- sclk, input, 1, SPI clock from the master (asynchronous).
- cs_n, input, 1, active-low chip select from the master (asynchronous).
- mosi, input, 1, serial data from the master (asynchronous).
- miso, output, 1, serial data to the master. Forced 0 while deselected.
- cpol, input, 1, clock idle level. Latched at selection.
- cpha, input, 1, 0 = sample on leading edge, 1 = sample on trailing edge. Latched at selection.
- tx_data, input, WIDTH, next word to transmit.
- tx_load, input, 1, writes tx_data into the buffer when tx_ready=1.
- tx_ready, output, 1, tx buffer empty.
- rx_data, output, WIDTH, last received word.
- rx_valid, output, 1, rx_data holds an unacknowledged word.
- rx_ack, input, 1, consumer accepts rx_data.
- busy, output, 1, slave selected (synchronized cs_n low).
- overrun, output, 1, sticky flag: a word completed while rx_valid=1.

Behaviour:
- Reset values: miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, overrun=0. Also bit counter=0, state=IDLE, and all synchronizer flops at their idle levels (sclk=cpol, cs_n=1).
- Synchronization:
  - sclk, cs_n and mosi each pass through a SYNC_STAGES flop chain. An edge is a change between the last sync stage and one extra history flop.
  - Effects of an edge are registered exactly SYNC_STAGES clk edges after the first clk edge that captures the new pin level.
  - Master constraint: each sclk half-period must be at least SYNC_STAGES+2 clk periods, and mosi must be stable at the sample edge.
- Edge classification:
  - Leading edge = sclk moving away from cpol_l. Trailing edge = sclk returning to cpol_l.
  - Sample edge = leading if cpha_l=0, trailing if cpha_l=1. The shift edge is the other one.
- State machine:
  - IDLE: busy=0, miso=0. On a synchronized cs_n fall: latch cpol_l/cpha_l, load the tx shift register (buffer if full, else TX_DEFAULT), set tx_ready=1, counter=0, go to XFER.
  - XFER:
    - Each sample edge shifts mosi into the LSB of rx_shift and increments the counter.
    - On the WIDTH-th sample edge: counter wraps to 0 and the full word goes to rx_data. Then rx_valid=1; overrun is set if rx_valid was already 1 and no rx_ack arrived that cycle. The tx shift register is then reloaded, per the cpha rules below.
    - On a synchronized cs_n rise: return to IDLE. A partial word (counter≠0) is discarded, with no rx_valid and no overrun. rx_data is unchanged.
- miso timing:
  - cpha_l=0: miso = tx_shift MSB, valid within SYNC_STAGES+1 clk of the cs_n fall. Each trailing edge shifts left, except the trailing edge after the WIDTH-th sample, which reloads instead.
  - cpha_l=1: miso is 0 until the first leading edge. Each leading edge registers the tx_shift MSB onto miso, then shifts. The reload occurs on the WIDTH-th sample (trailing) edge.
- Tx buffer:
  - tx_load with tx_ready=1 stores tx_data and sets tx_ready=0. tx_load with tx_ready=0 is ignored.
  - If a load and a buffer consume land in the same cycle, the consume takes the old contents and the new word is stored, leaving tx_ready=0.
- Rx handshake:
  - rx_ack clears rx_valid.
  - If rx_ack coincides with word completion, the new word is stored, rx_valid stays 1 and there is no overrun.
- Signals while busy: cpol/cpha changes are ignored. sclk edges while in IDLE are ignored.
- Reset mid-transfer returns everything to reset values. The block re-enters XFER only after cs_n is seen high and then falls again.

Test Plan:
- Mode 0 (cpol=0, cpha=0), tx buffer loaded with 0xA5, master shifts 0x8F → rx_data=0x8F, rx_valid pulses high once, master captures 0xA5, tx_ready=1 after the cs_n fall.
- Mode 1 (0/1), buffer 0x3C, master sends 0x49; then mode 3 (1/1) with master sending 0x81 → rx_data=0x49 then 0x81; master receives 0x3C, then 0xFF (buffer empty, TX_DEFAULT).
- Mode 2 (1/0), two back-to-back words 0xB9, 0x12 with cs_n held low; rx_ack pulsed between words; buffer loaded with 0x55 mid-first-word → two rx_valid events, overrun=0, master receives TX_DEFAULT then 0x55.
- Same back-to-back 0xB9, 0x12 without rx_ack → overrun=1 after the second word, rx_data=0x12; overrun stays 1 until reset.
- cs_n deasserted after 3 sample edges, then a full transfer of 0x0F → no rx_valid from the aborted word, then rx_data=0x0F; busy follows synchronized cs_n.
- reset asserted after 4 bits → all outputs at reset values next cycle. With cs_n held low, sclk toggles produce nothing; after cs_n rises and falls, a 0xC3 transfer is received correctly.

Source files
------------

// File: rtl/spi_slave_sampler_if.sv
// Bundle of SPI pins, mode straps and local tx/rx handshake signals for
// spi_slave_sampler. The slave modport is the endpoint's view; the master
// modport is the view of whoever drives the SPI pins and the local side.
`timescale 1ns/1ps
interface spi_slave_sampler_if #(
    parameter int WIDTH = 8
);
    // SPI pins (sclk/cs_n/mosi are asynchronous to the endpoint clock)
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;
    // Mode straps, latched at selection
    logic             cpol;
    logic             cpha;
    // Handshakes:
    //   tx: a word transfers when tx_load=1 and tx_ready=1 on the same rising
    //       clk edge; tx_load while tx_ready=0 has no effect.
    //   rx: rx_data is meaningful while rx_valid=1; the word is consumed on a
    //       rising clk edge with rx_ack=1. rx_valid never drops without rx_ack
    //       (or reset), and a new word may replace rx_data while rx_valid=1,
    //       which raises the sticky overrun flag unless rx_ack lands with it.
    logic [WIDTH-1:0] tx_data;
    logic             tx_load;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ack;
    // Status
    logic             busy;
    logic             overrun;
    // FSM state for checkers: 0 = IDLE, 1 = XFER
    logic             state_dbg;

    modport slave (
        input  sclk, cs_n, mosi, cpol, cpha, tx_data, tx_load, rx_ack,
        output miso, tx_ready, rx_data, rx_valid, busy, overrun, state_dbg
    );

    modport master (
        output sclk, cs_n, mosi, cpol, cpha, tx_data, tx_load, rx_ack,
        input  miso, tx_ready, rx_data, rx_valid, busy, overrun, state_dbg
    );
endinterface

// File: rtl/spi_slave_sampler.sv
// Oversampled SPI slave endpoint. sclk/cs_n/mosi are synchronized into clk,
// edges are found against a history flop, and a two-state FSM shifts words
// in and out in any cpol/cpha mode, MSB first, back-to-back while selected.
`timescale 1ns/1ps
module spi_slave_sampler #(
    parameter int                 WIDTH       = 8,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0]   TX_DEFAULT  = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_slave_sampler_if.slave    bus
);
    localparam int               CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Synchronizers and edge history
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_hist;
    logic                   cs_hist;
    // Marks when the history flop holds a pin-derived value after reset
    logic [SYNC_STAGES:0]   settle;

    // FSM and datapath state
    state_t                 state;
    logic                   armed;
    logic                   cpol_l;
    logic                   cpha_l;
    logic [CW-1:0]          bit_cnt;
    logic [WIDTH-1:0]       rx_shift;
    logic [WIDTH-1:0]       tx_shift;
    logic [WIDTH-1:0]       tx_buf;
    logic                   tx_empty;
    logic [WIDTH-1:0]       rx_hold;
    logic                   rx_full;
    logic                   overrun_flag;
    logic                   miso_bit;
    logic                   busy_flag;
    logic                   reload_pend;

    // Decoded events
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_edge;
    logic                   lead_edge;
    logic                   trail_edge;
    logic                   sample_edge;
    logic                   shift_edge;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   word_end;
    logic                   consume;
    logic [WIDTH-1:0]       rx_word;
    logic [WIDTH-1:0]       tx_next;

    // Pin synchronizers; idle levels on reset so no false edge is seen
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= {SYNC_STAGES{bus.cpol}};
            sclk_hist <= bus.cpol;
            cs_sync   <= '1;
            cs_hist   <= 1'b1;
            mosi_sync <= '0;
            settle    <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            cs_hist   <= cs_sync[SYNC_STAGES-1];
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edge classification against the latched mode
    always_comb begin
        sclk_s      = sclk_sync[SYNC_STAGES-1];
        cs_s        = cs_sync[SYNC_STAGES-1];
        mosi_s      = mosi_sync[SYNC_STAGES-1];
        sclk_edge   = sclk_s ^ sclk_hist;
        lead_edge   = sclk_edge && (sclk_s != cpol_l);
        trail_edge  = sclk_edge && (sclk_s == cpol_l);
        sample_edge = cpha_l ? trail_edge : lead_edge;
        shift_edge  = cpha_l ? lead_edge : trail_edge;
        // A fall only counts once cs_n has been seen high from the pin itself,
        // so a master still holding cs_n low through reset is not reselected.
        cs_fall     = armed && cs_hist && !cs_s;
        cs_rise     = !cs_hist && cs_s;
        word_end    = sample_edge && (bit_cnt == LAST);
        rx_word     = {rx_shift[WIDTH-2:0], mosi_s};
        tx_next     = tx_empty ? TX_DEFAULT : tx_buf;
        consume     = 1'b0;
        if (state == IDLE) begin
            consume = cs_fall;
        end else if (!cs_rise) begin
            consume = cpha_l ? word_end : (shift_edge && reload_pend);
        end
    end

    // Main FSM with the tx buffer and rx handshake; all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            armed        <= 1'b0;
            cpol_l       <= 1'b0;
            cpha_l       <= 1'b0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            tx_buf       <= '0;
            tx_empty     <= 1'b1;
            rx_hold      <= '0;
            rx_full      <= 1'b0;
            overrun_flag <= 1'b0;
            miso_bit     <= 1'b0;
            busy_flag    <= 1'b0;
            reload_pend  <= 1'b0;
        end else begin
            if (settle[SYNC_STAGES] && cs_s) begin
                armed <= 1'b1;
            end

            if (bus.rx_ack) begin
                rx_full <= 1'b0;
            end

            // A consume empties the buffer; a same-cycle accepted load refills it
            if (consume) begin
                tx_empty <= 1'b1;
            end
            if (bus.tx_load && tx_empty) begin
                tx_buf   <= bus.tx_data;
                tx_empty <= 1'b0;
            end

            case (state)
                IDLE: begin
                    miso_bit    <= 1'b0;
                    busy_flag   <= 1'b0;
                    bit_cnt     <= '0;
                    reload_pend <= 1'b0;
                    if (cs_fall) begin
                        state     <= XFER;
                        busy_flag <= 1'b1;
                        cpol_l    <= bus.cpol;
                        cpha_l    <= bus.cpha;
                        tx_shift  <= tx_next;
                        // cpha=0 presents the MSB before the first edge
                        miso_bit  <= bus.cpha ? 1'b0 : tx_next[WIDTH-1];
                    end
                end

                XFER: begin
                    if (cs_rise) begin
                        // Any partial word is simply dropped
                        state       <= IDLE;
                        busy_flag   <= 1'b0;
                        miso_bit    <= 1'b0;
                        bit_cnt     <= '0;
                        reload_pend <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= rx_word;
                            if (word_end) begin
                                bit_cnt <= '0;
                                rx_hold <= rx_word;
                                rx_full <= 1'b1;
                                if (rx_full && !bus.rx_ack) begin
                                    overrun_flag <= 1'b1;
                                end
                                if (cpha_l) begin
                                    tx_shift <= tx_next;
                                end else begin
                                    reload_pend <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            if (cpha_l) begin
                                miso_bit <= tx_shift[WIDTH-1];
                                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                            end else if (reload_pend) begin
                                tx_shift    <= tx_next;
                                miso_bit    <= tx_next[WIDTH-1];
                                reload_pend <= 1'b0;
                            end else begin
                                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                                miso_bit <= tx_shift[WIDTH-2];
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.miso      = miso_bit;
    assign bus.tx_ready  = tx_empty;
    assign bus.rx_data   = rx_hold;
    assign bus.rx_valid  = rx_full;
    assign bus.busy      = busy_flag;
    assign bus.overrun   = overrun_flag;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_spi_slave_sampler.sv
// Directed bench for spi_slave_sampler: a task-driven SPI master, a monitor
// that pops expected rx words from a queue, and direct checks of miso words
// and status flags.
`timescale 1ns/1ps
module tb_spi_slave_sampler;
    localparam int W    = 8;
    localparam int HALF = 8;   // sclk half-period in clk cycles

    // Clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_slave_sampler_if #(.WIDTH(W)) bus ();

    spi_slave_sampler #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .TX_DEFAULT  (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    int           n_cmp     = 0;
    int           n_err     = 0;
    int           rx_events = 0;
    bit           auto_ack  = 1'b1;
    logic         mon_ack   = 1'b0;
    logic         stim_ack  = 1'b0;
    logic         prev_valid = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic [W-1:0] mon_exp;
    logic [W-1:0] m1, m2, dummy;
    int           ev0;

    assign bus.rx_ack = mon_ack | stim_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a new word is rx_valid rising or rx_data changing while valid
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.rx_valid && (!prev_valid || bus.rx_data != prev_data)) begin
                rx_events++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rx_unexpected: got 0x%0h, expected no word", bus.rx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rx_word", bus.rx_data, mon_exp);
                end
                if (auto_ack) begin
                    mon_ack = 1'b1;
                    @(negedge clk);
                    mon_ack = 1'b0;
                end
            end
            prev_valid = bus.rx_valid;
            prev_data  = bus.rx_data;
        end
    end

    // Driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [W-1:0] d);
        @(negedge clk);
        bus.tx_data = d;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
    endtask

    task automatic select(input logic pol, input logic pha);
        @(negedge clk);
        bus.cpol = pol;
        bus.cpha = pha;
        bus.sclk = pol;
        wait_clk(HALF);
        bus.cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic deselect();
        wait_clk(HALF);
        bus.cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // Shifts nbits of mo (MSB first) and returns what the master sampled
    task automatic spi_bits(input logic pol, input logic pha, input logic [W-1:0] mo,
                            input int nbits, output logic [W-1:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!pha) begin
                bus.mosi = mo[W-1-i];
                wait_clk(HALF);
                mi[W-1-i] = bus.miso;
                bus.sclk  = ~pol;
                wait_clk(HALF);
                bus.sclk  = pol;
            end else begin
                bus.sclk  = ~pol;
                bus.mosi  = mo[W-1-i];
                wait_clk(HALF);
                mi[W-1-i] = bus.miso;
                bus.sclk  = pol;
                wait_clk(HALF);
            end
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"},     bus.miso,     1'b0);
        check({tag, "_tx_ready"}, bus.tx_ready, 1'b1);
        check({tag, "_rx_data"},  bus.rx_data,  8'h00);
        check({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
        check({tag, "_busy"},     bus.busy,     1'b0);
        check({tag, "_overrun"},  bus.overrun,  1'b0);
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        reset       = 1'b1;
        bus.sclk    = 1'b0;
        bus.cs_n    = 1'b1;
        bus.mosi    = 1'b0;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        bus.tx_data = '0;
        bus.tx_load = 1'b0;
        wait_clk(3);
        check_reset_values("init");
        reset = 1'b0;
        wait_clk(5);

        // Mode 0: buffer 0xA5, master sends 0x8F
        load(8'hA5);
        check("t1_tx_ready_loaded", bus.tx_ready, 1'b0);
        exp_q.push_back(8'h8F);
        ev0 = rx_events;
        select(1'b0, 1'b0);
        check("t1_tx_ready_after_fall", bus.tx_ready, 1'b1);
        check("t1_busy", bus.busy, 1'b1);
        spi_bits(1'b0, 1'b0, 8'h8F, 8, m1);
        deselect();
        check("t1_master_rx", m1, 8'hA5);
        wait_drain("t1_drain");
        check("t1_rx_events", rx_events - ev0, 1);
        check("t1_busy_after", bus.busy, 1'b0);

        // Mode 1 then mode 3
        load(8'h3C);
        exp_q.push_back(8'h49);
        select(1'b0, 1'b1);
        spi_bits(1'b0, 1'b1, 8'h49, 8, m1);
        deselect();
        check("t2_master_rx_mode1", m1, 8'h3C);
        exp_q.push_back(8'h81);
        select(1'b1, 1'b1);
        spi_bits(1'b1, 1'b1, 8'h81, 8, m2);
        deselect();
        check("t2_master_rx_mode3", m2, 8'hFF);
        wait_drain("t2_drain");
        check("t2_rx_data", bus.rx_data, 8'h81);

        // Mode 2 back-to-back with acks, buffer loaded mid-word
        exp_q.push_back(8'hB9);
        exp_q.push_back(8'h12);
        ev0 = rx_events;
        select(1'b1, 1'b0);
        fork
            spi_bits(1'b1, 1'b0, 8'hB9, 8, m1);
            begin
                wait_clk(3 * HALF);
                load(8'h55);
            end
        join
        spi_bits(1'b1, 1'b0, 8'h12, 8, m2);
        deselect();
        check("t3_master_rx_w1", m1, 8'hFF);
        check("t3_master_rx_w2", m2, 8'h55);
        wait_drain("t3_drain");
        check("t3_rx_events", rx_events - ev0, 2);
        check("t3_overrun", bus.overrun, 1'b0);

        // Same back-to-back without acks
        auto_ack = 1'b0;
        exp_q.push_back(8'hB9);
        exp_q.push_back(8'h12);
        select(1'b1, 1'b0);
        spi_bits(1'b1, 1'b0, 8'hB9, 8, m1);
        spi_bits(1'b1, 1'b0, 8'h12, 8, m2);
        deselect();
        check("t4_master_rx_w1", m1, 8'hFF);
        check("t4_master_rx_w2", m2, 8'hFF);
        wait_drain("t4_drain");
        check("t4_overrun", bus.overrun, 1'b1);
        check("t4_rx_data", bus.rx_data, 8'h12);
        check("t4_rx_valid", bus.rx_valid, 1'b1);
        @(negedge clk);
        stim_ack = 1'b1;
        @(negedge clk);
        stim_ack = 1'b0;
        wait_clk(2);
        check("t4_rx_valid_acked", bus.rx_valid, 1'b0);
        check("t4_overrun_sticky", bus.overrun, 1'b1);
        auto_ack = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t4_overrun_reset", bus.overrun, 1'b0);
        reset = 1'b0;
        wait_clk(5);

        // Aborted word after 3 sample edges, then 0x0F
        ev0 = rx_events;
        select(1'b0, 1'b0);
        check("t5_busy_sel", bus.busy, 1'b1);
        spi_bits(1'b0, 1'b0, 8'hF0, 3, dummy);
        deselect();
        check("t5_busy_desel", bus.busy, 1'b0);
        check("t5_no_rx_event", rx_events - ev0, 0);
        check("t5_rx_valid", bus.rx_valid, 1'b0);
        exp_q.push_back(8'h0F);
        select(1'b0, 1'b0);
        spi_bits(1'b0, 1'b0, 8'h0F, 8, m1);
        deselect();
        check("t5_master_rx", m1, 8'hFF);
        wait_drain("t5_drain");
        check("t5_rx_data", bus.rx_data, 8'h0F);

        // Reset mid-transfer
        select(1'b0, 1'b0);
        load(8'h77);
        check("t6_tx_ready_loaded", bus.tx_ready, 1'b0);
        spi_bits(1'b0, 1'b0, 8'hC3, 4, dummy);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("t6_reset");
        reset = 1'b0;
        ev0 = rx_events;
        spi_bits(1'b0, 1'b0, 8'hFF, 8, dummy);
        wait_clk(HALF);
        check("t6_busy_held_low", bus.busy, 1'b0);
        check("t6_no_rx_event", rx_events - ev0, 0);
        check("t6_rx_valid", bus.rx_valid, 1'b0);
        deselect();
        exp_q.push_back(8'hC3);
        select(1'b0, 1'b0);
        check("t6_busy_reselect", bus.busy, 1'b1);
        spi_bits(1'b0, 1'b0, 8'hC3, 8, m1);
        deselect();
        check("t6_master_rx", m1, 8'hFF);
        wait_drain("t6_drain");
        check("t6_rx_data", bus.rx_data, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
